// File: rtl/nn_avalon_pkg.sv
// Shared types and constants for the NN accelerator Avalon-MM host: FSM states,
// default address map and CSR bit positions.
package nn_avalon_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    WRITE,
    START,
    POLL_RD,
    POLL_WT,
    RES_RD,
    RES_WT,
    CLEAR,
    FINISH
  } state_e;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 16;
  localparam int RES_W  = 4;
  localparam int RDAT_W = 17;

  localparam int               DEF_PIXEL_WORDS  = 783;
  localparam int               DEF_WEIGHT_WORDS = 784;
  localparam logic [ADDR_W-1:0] DEF_RESULT_BASE = 11'h620;
  localparam int               DEF_RESULT_COUNT = 10;
  localparam logic [ADDR_W-1:0] DEF_CSR_ADDR    = 11'h62B;

  localparam int CSR_START_BIT = 3;
  localparam int CSR_DONE_BIT  = 4;

  localparam logic [DATA_W-1:0] CSR_START_CMD = 32'h1 << CSR_START_BIT;
  localparam logic [DATA_W-1:0] CSR_CLEAR_CMD = 32'h0;
  localparam logic [15:0]       POLL_LIMIT    = 16'hFFFF;

endpackage

// File: rtl/avalon_master_port.sv
// Single-transaction Avalon-MM master: latches one request, holds it through waitrequest,
// tracks the outstanding read and captures its readdata.
module avalon_master_port
  import nn_avalon_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              active_o,
  output logic              wr_ack_o,
  output logic              rd_acc_o,
  output logic              rd_vld_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              write_o,
  output logic              read_o,
  output logic [DATA_W-1:0] writedata_o,
  input  logic [DATA_W-1:0] readdata_i,
  input  logic              waitrequest_i,
  input  logic              readdatavalid_i
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic              pend_q, pend_d;
  logic              rvld_q, rvld_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign active_o = write_q | read_q | pend_q;
  assign wr_ack_o = write_q & ~waitrequest_i;
  assign rd_acc_o = read_q & ~waitrequest_i;

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    read_d  = read_q;
    pend_d  = pend_q;
    rvld_d  = 1'b0;
    rdata_d = rdata_q;
    if (wr_ack_o) begin
      write_d = 1'b0;
    end
    if (rd_acc_o) begin
      read_d = 1'b0;
      pend_d = 1'b1;
    end
    // Data beats with no read in flight are dropped here.
    if (pend_q && readdatavalid_i) begin
      pend_d  = 1'b0;
      rvld_d  = 1'b1;
      rdata_d = readdata_i;
    end
    if (!active_o && (wr_req_i || rd_req_i)) begin
      addr_d  = addr_i;
      wdata_d = wr_req_i ? wdata_i : '0;
      write_d = wr_req_i;
      read_d  = rd_req_i & ~wr_req_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      pend_q  <= 1'b0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      read_q  <= read_d;
      pend_q  <= pend_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
    end
  end

  assign address_o   = addr_q;
  assign writedata_o = wdata_q;
  assign write_o     = write_q;
  assign read_o      = read_q;
  assign rd_vld_o    = rvld_q;
  assign rd_data_o   = rdata_q;

endmodule

// File: rtl/nn_avalon_host.sv
// Host sequencer: streams pixel/weight words to the accelerator, starts it, polls the CSR,
// reads back the results and clears the CSR. NN_HOST_TIMEOUT_EN adds a bounded poll and error output.
module nn_avalon_host
  import nn_avalon_pkg::*;
#(
  parameter int                PIXEL_WORDS  = DEF_PIXEL_WORDS,
  parameter int                WEIGHT_WORDS = DEF_WEIGHT_WORDS,
  parameter logic [ADDR_W-1:0] RESULT_BASE  = DEF_RESULT_BASE,
  parameter int                RESULT_COUNT = DEF_RESULT_COUNT,
  parameter logic [ADDR_W-1:0] CSR_ADDR     = DEF_CSR_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [SRC_W-1:0]  src_data,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic              read,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest,
  input  logic              readdatavalid,
  output logic              result_valid,
  output logic [RES_W-1:0]  result_index,
  output logic [RDAT_W-1:0] result_data
`ifdef NN_HOST_TIMEOUT_EN
  ,
  output logic              error
`endif
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(PIXEL_WORDS + WEIGHT_WORDS - 1);
  localparam logic [RES_W-1:0]  LAST_RES  = RES_W'(RESULT_COUNT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [RES_W-1:0]  res_q, res_d;

  logic              wr_req, rd_req;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              port_active, wr_ack, rd_acc, rd_vld;
  logic [DATA_W-1:0] rd_data;
  logic              poll_hit;
  logic              unused_rd_data;

  assign unused_rd_data = ^rd_data[DATA_W-1:RDAT_W];

  avalon_master_port u_port (
    .clk             (clk),
    .rst             (rst),
    .wr_req_i        (wr_req),
    .rd_req_i        (rd_req),
    .addr_i          (req_addr),
    .wdata_i         (req_wdata),
    .active_o        (port_active),
    .wr_ack_o        (wr_ack),
    .rd_acc_o        (rd_acc),
    .rd_vld_o        (rd_vld),
    .rd_data_o       (rd_data),
    .address_o       (address),
    .write_o         (write),
    .read_o          (read),
    .writedata_o     (writedata),
    .readdata_i      (readdata),
    .waitrequest_i   (waitrequest),
    .readdatavalid_i (readdatavalid)
  );

  // Each bus state issues its request once the port is free and advances on completion.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    res_d     = res_q;
    wr_req    = 1'b0;
    rd_req    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          word_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = WRITE;
      WRITE: begin
        req_addr  = word_q;
        req_wdata = {{(DATA_W-SRC_W){1'b0}}, src_data};
        wr_req    = ~port_active;
        if (wr_ack) begin
          word_d  = word_q + 1'b1;
          state_d = (word_q == LAST_WORD) ? START : FETCH;
        end
      end
      START: begin
        req_addr  = CSR_ADDR;
        req_wdata = CSR_START_CMD;
        wr_req    = ~port_active;
        if (wr_ack) state_d = POLL_RD;
      end
      POLL_RD: begin
        req_addr = CSR_ADDR;
        rd_req   = ~port_active;
        if (rd_acc) state_d = POLL_WT;
      end
      POLL_WT: begin
        if (rd_vld) begin
          if (rd_data[CSR_DONE_BIT]) begin
            res_d   = '0;
            state_d = RES_RD;
          end else if (poll_hit) begin
            state_d = CLEAR;
          end else begin
            state_d = POLL_RD;
          end
        end
      end
      RES_RD: begin
        req_addr = RESULT_BASE + ADDR_W'(res_q);
        rd_req   = ~port_active;
        if (rd_acc) state_d = RES_WT;
      end
      RES_WT: begin
        if (rd_vld) begin
          res_d   = res_q + 1'b1;
          state_d = (res_q == LAST_RES) ? CLEAR : RES_RD;
        end
      end
      CLEAR: begin
        req_addr  = CSR_ADDR;
        req_wdata = CSR_CLEAR_CMD;
        wr_req    = ~port_active;
        if (wr_ack) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      res_q   <= res_d;
    end
  end

`ifdef NN_HOST_TIMEOUT_EN
  logic [15:0] poll_q, poll_d;
  logic        tmo_q, tmo_d;

  // Counts entries into POLL_RD; the limit is checked when a not-done status comes back.
  always_comb begin
    poll_d = poll_q;
    tmo_d  = tmo_q;
    if (state_q == IDLE && go) begin
      poll_d = '0;
      tmo_d  = 1'b0;
    end else if (state_d == POLL_RD && state_q != POLL_RD) begin
      poll_d = poll_q + 16'd1;
    end
    if (state_q == POLL_WT && state_d == CLEAR) tmo_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      poll_q <= poll_d;
      tmo_q  <= tmo_d;
    end
  end

  assign poll_hit = (poll_q == POLL_LIMIT);
  assign error    = (state_q == FINISH) && tmo_q;
`else
  assign poll_hit = 1'b0;
`endif

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FINISH);
  assign src_addr     = (state_q == FETCH) ? word_q : '0;
  assign result_valid = (state_q == RES_WT) && rd_vld;
  assign result_index = result_valid ? res_q : '0;
  assign result_data  = result_valid ? rd_data[RDAT_W-1:0] : '0;

endmodule

// File: tb/tb_nn_avalon_host.sv
// Scoreboard bench for nn_avalon_host: a transaction-level model predicts every Avalon
// transfer, result beat and done pulse; a monitor checks them as the DUT presents them.
module tb_nn_avalon_host;

  localparam int          TOTAL = 1567;
  localparam logic [10:0] CSR   = 11'h62B;
  localparam logic [10:0] RBASE = 11'h620;
`ifdef NN_HOST_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  typedef struct packed {
    logic        is_wr;
    logic [10:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct packed {
    logic [3:0]  idx;
    logic [16:0] data;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, go, busy, done;
  logic [10:0] src_addr;
  logic [15:0] src_data;
  logic [10:0] address;
  logic        write, read;
  logic [31:0] writedata, readdata;
  logic        waitrequest, readdatavalid;
  logic        result_valid;
  logic [3:0]  result_index;
  logic [16:0] result_data;
`ifdef NN_HOST_TIMEOUT_EN
  logic        error;
`endif

  nn_avalon_host dut (
    .clk           (clk),
    .rst           (rst),
    .go            (go),
    .busy          (busy),
    .done          (done),
    .src_addr      (src_addr),
    .src_data      (src_data),
    .address       (address),
    .write         (write),
    .read          (read),
    .writedata     (writedata),
    .readdata      (readdata),
    .waitrequest   (waitrequest),
    .readdatavalid (readdatavalid),
    .result_valid  (result_valid),
    .result_index  (result_index),
    .result_data   (result_data)
`ifdef NN_HOST_TIMEOUT_EN
    ,
    .error         (error)
`endif
  );

  always #5 clk = ~clk;

  txn_t        exp_q[$];
  res_t        res_q[$];
  logic [31:0] csr_resp[$];
  logic [15:0] src_mem[TOTAL];
  logic [31:0] res_vals[10];
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          w5_cycles = 0;
  bit          exp_error = 1'b0;
  bit          stall_rand = 1'b0;
  bit          spur_en = 1'b0;
  bit          stall_armed = 1'b0;
  logic [10:0] stall_addr = 11'd5;
  logic [10:0] last_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_txn(input logic w, input logic [10:0] a, input logic [31:0] d);
    txn_t t;
    t.is_wr = w;
    t.addr  = a;
    t.data  = d;
    exp_q.push_back(t);
  endtask

  // Transaction-level prediction of one whole inference from the current stimulus tables.
  task automatic plan();
    int          polls;
    bit          fin;
    logic [31:0] resp;
    res_t        r;
    for (int i = 0; i < TOTAL; i++) push_txn(1'b1, 11'(i), {16'h0, src_mem[i]});
    push_txn(1'b1, CSR, 32'h8);
    polls = 0;
    fin = 1'b0;
    exp_error = 1'b0;
    while (!fin) begin
      push_txn(1'b0, CSR, 32'h0);
      resp = (polls < csr_resp.size()) ? csr_resp[polls] : 32'h8;
      polls++;
      if (resp[4]) begin
        for (int k = 0; k < 10; k++) begin
          push_txn(1'b0, RBASE + 11'(k), 32'h0);
          r.idx  = 4'(k);
          r.data = res_vals[k][16:0];
          res_q.push_back(r);
        end
        fin = 1'b1;
      end else if (TMO && polls == 65535) begin
        exp_error = 1'b1;
        fin = 1'b1;
      end
    end
    push_txn(1'b1, CSR, 32'h0);
  endtask

  task automatic start_run();
    plan();
    @(negedge clk); #2;
    go = 1'b1;
    @(negedge clk); #2;
    go = 1'b0;
  endtask

  task automatic finish_run(input int runs, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    check("done_seen", {31'b0, done}, 32'h1);
    repeat (3) @(negedge clk);
    #2;
    check("txn_left", exp_q.size(), 0);
    check("results_left", res_q.size(), 0);
    check("done_pulses", done_cnt, runs);
    check("busy_after_done", {31'b0, busy}, 32'h0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 0);
    check({tag, "_done"}, {31'b0, done}, 0);
    check({tag, "_src_addr"}, {21'b0, src_addr}, 0);
    check({tag, "_address"}, {21'b0, address}, 0);
    check({tag, "_write"}, {31'b0, write}, 0);
    check({tag, "_read"}, {31'b0, read}, 0);
    check({tag, "_writedata"}, writedata, 0);
    check({tag, "_result_valid"}, {31'b0, result_valid}, 0);
    check({tag, "_result_index"}, {28'b0, result_index}, 0);
    check({tag, "_result_data"}, {15'b0, result_data}, 0);
`ifdef NN_HOST_TIMEOUT_EN
    check({tag, "_error"}, {31'b0, error}, 0);
`endif
  endtask

  task automatic random_tables(input int n_busy_polls);
    csr_resp.delete();
    for (int i = 0; i < TOTAL; i++) src_mem[i] = 16'($urandom);
    for (int k = 0; k < 10; k++) res_vals[k] = $urandom;
    for (int p = 0; p < n_busy_polls; p++) csr_resp.push_back($urandom & ~32'h10);
    csr_resp.push_back($urandom | 32'h10);
  endtask

  // Avalon slave and source memory.
  initial begin : slave
    bit          rd_out;
    int          rd_dly;
    int          stall_left;
    int          idx;
    logic [31:0] rd_resp;
    rd_out = 1'b0;
    rd_dly = 0;
    stall_left = 0;
    rd_resp = '0;
    waitrequest = 1'b0;
    readdatavalid = 1'b0;
    readdata = '0;
    src_data = '0;
    forever begin
      @(negedge clk);
      src_data = (int'(last_addr) < TOTAL) ? src_mem[last_addr] : 16'h0;
      last_addr = src_addr;
      if (rst) begin
        rd_out = 1'b0;
        stall_left = 0;
        waitrequest = 1'b0;
        readdatavalid = 1'b0;
      end else begin
        readdatavalid = 1'b0;
        if (rd_out) begin
          if (rd_dly == 0) begin
            readdatavalid = 1'b1;
            readdata = rd_resp;
            rd_out = 1'b0;
          end else begin
            rd_dly--;
          end
        end else if (spur_en && !read && $urandom_range(0, 5) == 0) begin
          readdatavalid = 1'b1;
          readdata = $urandom;
        end
        if (write && stall_armed && address == stall_addr) begin
          stall_left = 3;
          stall_armed = 1'b0;
        end
        if (stall_left > 0) begin
          waitrequest = 1'b1;
          stall_left--;
        end else begin
          waitrequest = stall_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        if (read && !waitrequest) begin
          rd_out = 1'b1;
          rd_dly = $urandom_range(0, 2);
          idx = int'(address) - int'(RBASE);
          if (address == CSR)
            rd_resp = (csr_resp.size() > 0) ? csr_resp.pop_front() : 32'h8;
          else if (idx >= 0 && idx < 10)
            rd_resp = res_vals[idx];
          else
            rd_resp = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin : monitor
    logic [10:0] p_addr;
    logic [31:0] p_wd;
    logic        p_wr, p_rd;
    bit          p_stall;
    txn_t        t;
    res_t        r;
    p_stall = 1'b0;
    p_addr = '0;
    p_wd = '0;
    p_wr = 1'b0;
    p_rd = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        p_stall = 1'b0;
      end else begin
        check("rw_exclusive", {31'b0, read & write}, 0);
        if (p_stall) begin
          check("stall_address", {21'b0, address}, {21'b0, p_addr});
          check("stall_writedata", writedata, p_wd);
          check("stall_write", {31'b0, write}, {31'b0, p_wr});
          check("stall_read", {31'b0, read}, {31'b0, p_rd});
        end
        p_stall = (write || read) && waitrequest;
        p_addr = address;
        p_wd = writedata;
        p_wr = write;
        p_rd = read;
        if (write && address == 11'd5) w5_cycles++;
        if ((write || read) && !waitrequest) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_txn: wr=%0b addr=0x%0h data=0x%0h, expected none", write, address, writedata);
          end else begin
            t = exp_q.pop_front();
            check("txn_kind_is_write", {31'b0, write}, {31'b0, t.is_wr});
            check("txn_address", {21'b0, address}, {21'b0, t.addr});
            if (t.is_wr) check("txn_writedata", writedata, t.data);
          end
        end
        if (result_valid) begin
          if (res_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: idx=%0d data=0x%0h, expected none", result_index, result_data);
          end else begin
            r = res_q.pop_front();
            check("result_index", {28'b0, result_index}, {28'b0, r.idx});
            check("result_data", {15'b0, result_data}, {15'b0, r.data});
          end
        end
        if (done) begin
          done_cnt++;
`ifdef NN_HOST_TIMEOUT_EN
          check("error_with_done", {31'b0, error}, {31'b0, exp_error});
`endif
        end
`ifdef NN_HOST_TIMEOUT_EN
        if (error && !done) check("error_without_done", {31'b0, error}, 0);
`endif
      end
    end
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    go = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_zero("reset");
    @(negedge clk); #2;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("idle_busy", {31'b0, busy}, 0);

    // Run 1: no stalls, source word = index, two busy polls then done.
    for (int i = 0; i < TOTAL; i++) src_mem[i] = 16'(i);
    for (int k = 0; k < 10; k++) res_vals[k] = 32'h1FFFF - 32'(k);
    csr_resp.delete();
    csr_resp.push_back(32'h8);
    csr_resp.push_back(32'h8);
    csr_resp.push_back(32'h18);
    start_run();
    finish_run(1, 20000);

    // Run 2: three-cycle stall on write #5, stray data beats, go while busy.
    random_tables($urandom_range(0, 3));
    stall_armed = 1'b1;
    spur_en = 1'b1;
    w5_cycles = 0;
    start_run();
    repeat (50) @(negedge clk);
    #2;
    check("busy_mid_run", {31'b0, busy}, 32'h1);
    go = 1'b1;
    @(negedge clk); #2;
    go = 1'b0;
    finish_run(2, 20000);
    check("write5_held_cycles", w5_cycles, 4);

    // Run 3: reset during write #100.
    random_tables(1);
    spur_en = 1'b0;
    start_run();
    n = 0;
    while (!(write && address == 11'd100) && n < 2000) begin
      @(negedge clk); #2;
      n++;
    end
    check("reached_write100", {21'b0, address}, 32'd100);
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    exp_q.delete();
    res_q.delete();
    csr_resp.delete();
    @(negedge clk); #2;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("no_restart_busy", {31'b0, busy}, 0);
    check("no_restart_write", {31'b0, write}, 0);

    // Run 4: restart after reset with random stalls and stray data beats.
    random_tables($urandom_range(0, 4));
    stall_rand = 1'b1;
    spur_en = 1'b1;
    start_run();
    finish_run(3, 30000);

`ifdef NN_HOST_TIMEOUT_EN
    // Run 5: accelerator never reports done.
    stall_rand = 1'b0;
    spur_en = 1'b0;
    for (int i = 0; i < TOTAL; i++) src_mem[i] = 16'($urandom);
    csr_resp.delete();
    start_run();
    finish_run(4, 500000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_avalon_host.md
NN_AVALON_HOST -- requirements
Module: nn_avalon_host

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PIXEL_WORDS, 783, pixel words written at Avalon addresses 0x000..0x30E
- WEIGHT_WORDS, 784, weight words written at 0x30F..0x61E
- RESULT_BASE, 11'h620, first result address
- RESULT_COUNT, 10, result words read
- CSR_ADDR, 11'h62B, control/status register address
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high. Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- go  in  1  single-cycle start-of-inference pulse
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when the sequence completes
- src_addr  out  11  source word index, 0..PIXEL_WORDS+WEIGHT_WORDS-1
- src_data  in  16  source word, valid one cycle after src_addr
- address  out  11  Avalon-MM address
- write  out  1  Avalon write request
- read  out  1  Avalon read request
- writedata  out  32  Avalon write data
- readdata  in  32  Avalon read data
- waitrequest  in  1  Avalon stall
- readdatavalid  in  1  Avalon read data qualifier
- result_valid  out  1  result_index and result_data valid this cycle
- result_index  out  4  result number, 0..9
- result_data  out  17  readdata[16:0] of that result

Function
REQ-003 The block SHALL use states IDLE, FETCH, WRITE, START, POLL_RD, POLL_WT, RES_RD, RES_WT, CLEAR, FINISH.
REQ-004 In IDLE, go SHALL load the word counter with 0 and move to FETCH; go while busy SHALL be ignored.
REQ-005 FETCH SHALL drive src_addr = counter for one cycle, then move to WRITE.
REQ-006 WRITE SHALL hold write=1, writedata = {16'b0, src_data registered}, and address = counter until waitrequest=0, then increment the counter.
REQ-007 After writing the last word (counter = PIXEL_WORDS+WEIGHT_WORDS-1), the block SHALL go to START; otherwise it SHALL return to FETCH.
REQ-008 START SHALL write 32'h0000_0008 to CSR_ADDR, holding it until waitrequest=0.
REQ-009 POLL_RD SHALL assert read at CSR_ADDR until waitrequest=0. POLL_WT SHALL wait for readdatavalid. If readdata[4]=1 the block SHALL go to RES_RD; otherwise it SHALL go back to POLL_RD.
REQ-010 RES_RD/RES_WT SHALL read RESULT_BASE+i for i = 0..RESULT_COUNT-1, one outstanding read at a time. Each readdatavalid SHALL produce one result_valid pulse with result_index=i.
REQ-011 CLEAR SHALL write 32'h0 to CSR_ADDR. FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-012 read and write SHALL never be high together. address/writedata SHALL stay stable while waitrequest=1.
REQ-013 A readdatavalid that arrives while no read is outstanding SHALL be ignored.
REQ-014 busy SHALL be 1 in every state except IDLE.

Reset
REQ-015 While rst=1, the block SHALL be in IDLE with the counters at 0 and every output at 0, including mid-transfer; it SHALL restart only on a later go.

Configuration
REQ-016 With NN_HOST_TIMEOUT_EN defined:
- a 16-bit poll counter SHALL count POLL_RD entries;
- when it reaches 16'hFFFF the block SHALL go to CLEAR without reading results, and the extra output error (1 bit) SHALL pulse together with done.
REQ-017 Without NN_HOST_TIMEOUT_EN, the error port and the poll counter SHALL be absent, and polling SHALL be unbounded.

Structure
REQ-018 Package nn_avalon_pkg SHALL hold the state enum, the address constants, and CSR bit positions START=3 and DONE=4.
REQ-019 Sub-module avalon_master_port SHALL hold the single-transaction handshake (request hold, waitrequest release, readdatavalid capture); the FSM and counters SHALL live in nn_avalon_host.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- go, with waitrequest=0 throughout and src_data = index -> 1567 writes; address 0x30E carries 0x30E; the last load write is to 0x61E; then 0x8 is written to 0x62B.
- waitrequest held high for 3 cycles on write #5 -> address and writedata stable all 4 cycles; no duplicate write.
- CSR read returns 0x8 twice, then 0x18 -> exactly 3 polls, then reads at 0x620..0x629.
- result reads return 0x1FFFF..0x1FFF6 -> 10 result_valid pulses with indices 0..9 and matching data; then 0x0 is written to 0x62B; one done pulse.
- rst asserted during write #100 -> all outputs 0 that cycle; a following go restarts at address 0x000.
- NN_HOST_TIMEOUT_EN defined and DONE never set -> after 65535 polls, error and done pulse together, and no result reads occur.
